// File: rtl/hazard_control_unit.sv
// Pipeline hazard and freeze controller for the 5-stage RV64 core.
// It has three parts:
//   - combinational operand forwarding, load-use stall and branch flush;
//   - a refill sequencer FSM that freezes the whole pipeline while an
//     I- or D-cache refill is outstanding;
//   - a saturating counter of cycles in which fetch was stalled.
module hazard_control_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
   input  logic                  i_load_exec,
   input  logic                  i_reg_we_mem,
   input  logic                  i_reg_we_wb,
   input  logic                  i_pc_src_exec,
   input  logic                  i_icache_miss,
   input  logic                  i_dcache_miss,
   input  logic                  i_refill_done,
   input  logic                  i_cnt_clear,
   output logic                  o_stall_fetch,
   output logic                  o_stall_dec,
   output logic                  o_stall_exec,
   output logic                  o_stall_mem,
   output logic                  o_flush_dec,
   output logic                  o_flush_exec,
   output logic [1:0]            o_forward_rs1,
   output logic [1:0]            o_forward_rs2,
   output logic                  o_refill_req,
   output logic                  o_refill_is_data,
   output logic [CNT_W-1:0]      o_stall_cnt
);

   // Forward select encodings seen by the EXEC operand muxes.
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
   localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // RUN: pipeline flowing. D_WAIT / I_WAIT: a data / instruction refill
   // is outstanding and the pipeline is frozen.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } state_t;

   state_t state;

   logic load_use;
   logic freeze;

   // Picks the youngest in-flight producer of a source register. x0 is
   // hard-wired to zero, so it is never forwarded. MEM holds the newer
   // value, so it wins over WB.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] rd_mem,
      input logic                  we_mem,
      input logic [REG_ADDR_W-1:0] rd_wb,
      input logic                  we_wb
   );
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (src != REG_ZERO) begin
         if (we_mem && (src == rd_mem)) begin
            sel = FWD_MEM;
         end else if (we_wb && (src == rd_wb)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

   // Forwarding selects for both EXEC operands.
   always_comb begin
      o_forward_rs1 = fwd_sel(i_rs1_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                              i_rd_addr_wb, i_reg_we_wb);
      o_forward_rs2 = fwd_sel(i_rs2_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                              i_rd_addr_wb, i_reg_we_wb);
   end

   // Hazard detection and the stall / flush equations. A load in EXEC
   // cannot forward to DEC in time, so DEC and fetch hold and a bubble is
   // pushed into EXEC. A freeze holds every stage and masks flushes; a
   // frozen branch in EXEC keeps i_pc_src_exec high, so its flush fires on
   // the first unfrozen cycle.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a value on every
      // path, starting with a default here, so no latch is inferred.
      load_use      = 1'b0;
      freeze        = 1'b0;
      o_stall_fetch = 1'b0;
      o_stall_dec   = 1'b0;
      o_stall_exec  = 1'b0;
      o_stall_mem   = 1'b0;
      o_flush_dec   = 1'b0;
      o_flush_exec  = 1'b0;

      load_use = i_load_exec && (i_rd_addr_exec != REG_ZERO) &&
                 ((i_rd_addr_exec == i_rs1_addr_dec) ||
                  (i_rd_addr_exec == i_rs2_addr_dec));

      // A miss freezes in the same cycle it is seen, before the FSM has
      // registered it, so the raw miss flags are part of the freeze term.
      freeze = (state != RUN) || i_icache_miss || i_dcache_miss;

      o_stall_fetch = load_use || freeze;
      o_stall_dec   = load_use || freeze;
      o_stall_exec  = freeze;
      o_stall_mem   = freeze;
      o_flush_dec   = i_pc_src_exec && !freeze;
      o_flush_exec  = (i_pc_src_exec || load_use) && !freeze;
   end

   // Refill sequencer with registered request outputs. The data miss goes
   // first because it belongs to the older instruction; an instruction
   // miss still pending when the data refill ends chains straight into an
   // I-cache refill, keeping o_refill_req high across the hand-over.
   // A refill-done pulse while in RUN has no refill to finish and is ignored.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state            <= RUN;
         o_refill_req     <= 1'b0;
         o_refill_is_data <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the values from before this clock edge.
         case (state)
            RUN: begin
               if (i_dcache_miss) begin
                  state            <= D_WAIT;
                  o_refill_req     <= 1'b1;
                  o_refill_is_data <= 1'b1;
               end else if (i_icache_miss) begin
                  state            <= I_WAIT;
                  o_refill_req     <= 1'b1;
                  o_refill_is_data <= 1'b0;
               end
            end
            D_WAIT: begin
               if (i_refill_done) begin
                  o_refill_is_data <= 1'b0;
                  if (i_icache_miss) begin
                     state        <= I_WAIT;
                     o_refill_req <= 1'b1;
                  end else begin
                     state        <= RUN;
                     o_refill_req <= 1'b0;
                  end
               end
            end
            I_WAIT: begin
               if (i_refill_done) begin
                  state            <= RUN;
                  o_refill_req     <= 1'b0;
                  o_refill_is_data <= 1'b0;
               end
            end
            default: begin
               state            <= RUN;
               o_refill_req     <= 1'b0;
               o_refill_is_data <= 1'b0;
            end
         endcase
      end
   end

   // Stall-cycle counter for performance analysis. Clear wins over count,
   // and the count sticks at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         o_stall_cnt <= '0;
      end else if (i_cnt_clear) begin
         o_stall_cnt <= '0;
      end else if (o_stall_fetch && (o_stall_cnt != CNT_MAX)) begin
         o_stall_cnt <= o_stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit. The stimulus process drives
// one directed vector per cycle and pushes its hand-computed expectation
// into a scoreboard queue; a monitor pops one entry per falling edge and
// compares it with both DUT instances (32-bit and 4-bit stall counter).
module tb_hazard_control_unit;

   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          arstn;
   logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec;
   logic [AW-1:0] rd_exec, rd_mem, rd_wb;
   logic          load_exec, we_mem, we_wb, pc_src;
   logic          imiss, dmiss, refill_done, cnt_clear;

   // Main instance outputs
   logic        sf, sd, se, sm, fd, fe, rq, rd;
   logic [1:0]  f1, f2;
   logic [31:0] cnt;

   // Narrow-counter instance outputs
   logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_rq, s_rd;
   logic [1:0]  s_f1, s_f2;
   logic [3:0]  s_cnt;

   hazard_control_unit #(.REG_ADDR_W(AW), .CNT_W(32)) dut (
      .i_clk(clk), .i_arstn(arstn),
      .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
      .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec),
      .i_rd_addr_exec(rd_exec), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
      .i_load_exec(load_exec), .i_reg_we_mem(we_mem), .i_reg_we_wb(we_wb),
      .i_pc_src_exec(pc_src), .i_icache_miss(imiss), .i_dcache_miss(dmiss),
      .i_refill_done(refill_done), .i_cnt_clear(cnt_clear),
      .o_stall_fetch(sf), .o_stall_dec(sd), .o_stall_exec(se), .o_stall_mem(sm),
      .o_flush_dec(fd), .o_flush_exec(fe),
      .o_forward_rs1(f1), .o_forward_rs2(f2),
      .o_refill_req(rq), .o_refill_is_data(rd), .o_stall_cnt(cnt)
   );

   hazard_control_unit #(.REG_ADDR_W(AW), .CNT_W(4)) dut_small (
      .i_clk(clk), .i_arstn(arstn),
      .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
      .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec),
      .i_rd_addr_exec(rd_exec), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
      .i_load_exec(load_exec), .i_reg_we_mem(we_mem), .i_reg_we_wb(we_wb),
      .i_pc_src_exec(pc_src), .i_icache_miss(imiss), .i_dcache_miss(dmiss),
      .i_refill_done(refill_done), .i_cnt_clear(cnt_clear),
      .o_stall_fetch(s_sf), .o_stall_dec(s_sd), .o_stall_exec(s_se), .o_stall_mem(s_sm),
      .o_flush_dec(s_fd), .o_flush_exec(s_fe),
      .o_forward_rs1(s_f1), .o_forward_rs2(s_f2),
      .o_refill_req(s_rq), .o_refill_is_data(s_rd), .o_stall_cnt(s_cnt)
   );

   typedef struct {
      string       name;
      logic        sf, se, fd, fe, rq, rd;
      logic [1:0]  f1, f2;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] exp_cnt  = '0;
   logic [3:0]  exp_cnt4 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check({mon_e.name, ".stall_fetch"}, 32'(sf), 32'(mon_e.sf));
         check({mon_e.name, ".stall_dec"},   32'(sd), 32'(mon_e.sf));
         check({mon_e.name, ".stall_exec"},  32'(se), 32'(mon_e.se));
         check({mon_e.name, ".stall_mem"},   32'(sm), 32'(mon_e.se));
         check({mon_e.name, ".flush_dec"},   32'(fd), 32'(mon_e.fd));
         check({mon_e.name, ".flush_exec"},  32'(fe), 32'(mon_e.fe));
         check({mon_e.name, ".fwd_rs1"},     32'(f1), 32'(mon_e.f1));
         check({mon_e.name, ".fwd_rs2"},     32'(f2), 32'(mon_e.f2));
         check({mon_e.name, ".refill_req"},  32'(rq), 32'(mon_e.rq));
         check({mon_e.name, ".is_data"},     32'(rd), 32'(mon_e.rd));
         check({mon_e.name, ".cnt"},         cnt,     mon_e.cnt);
         check({mon_e.name, ".s.stall"},     32'({s_sf, s_sd, s_se, s_sm}),
               32'({mon_e.sf, mon_e.sf, mon_e.se, mon_e.se}));
         check({mon_e.name, ".s.flush_fwd"}, 32'({s_fd, s_fe, s_f1, s_f2}),
               32'({mon_e.fd, mon_e.fe, mon_e.f1, mon_e.f2}));
         check({mon_e.name, ".s.refill"},    32'({s_rq, s_rd}), 32'({mon_e.rq, mon_e.rd}));
         check({mon_e.name, ".s.cnt4"},      32'(s_cnt), 32'(mon_e.cnt4));
      end
   end

   task automatic idle_inputs();
      rs1_dec = '0; rs2_dec = '0; rs1_exec = '0; rs2_exec = '0;
      rd_exec = '0; rd_mem = '0; rd_wb = '0;
      load_exec = 1'b0; we_mem = 1'b0; we_wb = 1'b0; pc_src = 1'b0;
      imiss = 1'b0; dmiss = 1'b0; refill_done = 1'b0; cnt_clear = 1'b0;
   endtask

   // Inputs are already applied (just after a rising edge). Queue the
   // expectation for this cycle, advance the counter reference, then move
   // to just after the next rising edge.
   task automatic step(input string name, input logic e_sf, input logic e_se,
                       input logic e_fd, input logic e_fe,
                       input logic [1:0] e_f1, input logic [1:0] e_f2,
                       input logic e_rq, input logic e_rd);
      exp_t e;
      if (!arstn) begin
         exp_cnt  = '0;
         exp_cnt4 = '0;
      end
      e.name = name;
      e.sf = e_sf; e.se = e_se; e.fd = e_fd; e.fe = e_fe;
      e.f1 = e_f1; e.f2 = e_f2; e.rq = e_rq; e.rd = e_rd;
      e.cnt = exp_cnt; e.cnt4 = exp_cnt4;
      sb.push_back(e);
      if (!arstn || cnt_clear) begin
         exp_cnt  = '0;
         exp_cnt4 = '0;
      end else if (e_sf) begin
         exp_cnt = exp_cnt + 32'd1;
         if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      arstn = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      step("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      arstn = 1'b1;
      step("idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Forwarding
      rs1_exec = 5; rd_mem = 5; we_mem = 1; rd_wb = 5; we_wb = 1;
      step("fwd_mem", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
      we_mem = 0;
      step("fwd_wb", 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
      rs1_exec = 0; rs2_exec = 5; we_mem = 1;
      step("fwd_x0_rs2mem", 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
      rs1_exec = 5; rs2_exec = 3; rd_wb = 3;
      step("fwd_mix", 0, 0, 0, 0, 2'b10, 2'b01, 0, 0);
      idle_inputs();

      // Load-use
      load_exec = 1; rd_exec = 7; rs2_dec = 7;
      step("lu_rs2", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
      rd_exec = 0;
      step("lu_rd0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      rd_exec = 7; rs2_dec = 0; rs1_dec = 7;
      step("lu_rs1", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
      load_exec = 0;
      step("lu_noload", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      idle_inputs();

      // Branch, then branch held across a D-miss freeze
      pc_src = 1;
      step("br", 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
      dmiss = 1;
      step("br_dmiss", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      dmiss = 0;
      step("br_dwait", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 1;
      step("br_done", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 0;
      step("br_release", 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
      idle_inputs();

      // D-miss refill
      dmiss = 1;
      step("dm_c0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      step("dm_c1", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      dmiss = 0;
      step("dm_c2", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      step("dm_c3", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 1;
      step("dm_c4", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 0;
      step("dm_c5", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Refill-done in RUN is ignored
      refill_done = 1;
      step("done_in_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      refill_done = 0;
      step("after_stray_done", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Simultaneous misses: data first, then chained instruction refill
      dmiss = 1; imiss = 1;
      step("both_c0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      step("both_c1", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      dmiss = 0;
      step("both_c2", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 1;
      step("both_c3", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      refill_done = 0;
      step("both_c4", 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
      imiss = 0;
      step("both_c5", 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
      refill_done = 1;
      step("both_c6", 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
      refill_done = 0;
      step("both_c7", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Counter: clear, 10 frozen cycles, clear during a stall
      cnt_clear = 1;
      step("cnt_clr0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      cnt_clear = 0;
      imiss = 1;
      for (int i = 0; i < 10; i++)
         step($sformatf("cnt_frz%0d", i), 1, 1, 0, 0, 2'b00, 2'b00, (i > 0), 0);
      imiss = 0; refill_done = 1; cnt_clear = 1;
      step("cnt_ten_clr", 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
      refill_done = 0; cnt_clear = 0;
      step("cnt_cleared", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // 20 load-use stall cycles: narrow counter saturates at 15
      load_exec = 1; rd_exec = 7; rs1_dec = 7;
      for (int i = 0; i < 20; i++)
         step($sformatf("cnt_lu%0d", i), 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
      idle_inputs();
      step("cnt_sat", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Reset asserted mid-refill
      dmiss = 1;
      step("rst_mid_c0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      step("rst_mid_c1", 1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
      arstn = 1'b0; dmiss = 0;
      step("rst_mid", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      arstn = 1'b1;
      step("rst_after", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
